object_move_2d: RTL and testbench



---
 rtl/object_move_2d_if.sv | 30 +++
 rtl/object_move_2d.sv | 201 ++++++++++++++++++++
 tb/tb_object_move_2d.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/object_move_2d_if.sv
// Control and position bundle between the keypad/collision logic and one sprite mover.
interface object_move_2d_if;
    logic               startOfFrame;
    logic               enable_sof;
    logic               respawn;
    logic               key_left;
    logic               key_right;
    logic               key_up;
    logic               key_down;
    logic               collision;
    logic [3:0]         HitEdgeCode;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic               edge_hit;
    logic               moving;

    modport master (
        output startOfFrame, enable_sof, respawn,
        output key_left, key_right, key_up, key_down,
        output collision, HitEdgeCode,
        input  topLeftX, topLeftY, edge_hit, moving
    );

    modport slave (
        input  startOfFrame, enable_sof, respawn,
        input  key_left, key_right, key_up, key_down,
        input  collision, HitEdgeCode,
        output topLeftX, topLeftY, edge_hit, moving
    );
endinterface

// File: rtl/object_move_2d.sv
// Two-axis fixed-point sprite mover: key-driven (PLAYER) or self-propelled
// with wall/collision reflection (BOUNCE), updated once per video frame.
module object_move_2d #(
    parameter int MODE      = 0,
    parameter int INITIAL_X = 280,
    parameter int INITIAL_Y = 185,
    parameter int SPEED_X   = 64,
    parameter int SPEED_Y   = 0,
    parameter int FP_SHIFT  = 6,
    parameter int OBJ_W     = 32,
    parameter int OBJ_H     = 32,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SAFETY    = 2
) (
    input  logic              clk,
    input  logic              reset,
    object_move_2d_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE_ST,
        MOVE_ST,
        SOF_ST,
        CHANGE_ST,
        LIMITS_ST
    } state_t;

    localparam logic signed [31:0] X_INIT = 32'(INITIAL_X << FP_SHIFT);
    localparam logic signed [31:0] Y_INIT = 32'(INITIAL_Y << FP_SHIFT);
    localparam logic signed [31:0] SPX    = 32'(SPEED_X);
    localparam logic signed [31:0] SPY    = 32'(SPEED_Y);
    localparam logic signed [31:0] VX_INIT = (MODE == 1) ? SPX : '0;
    localparam logic signed [31:0] VY_INIT = (MODE == 1) ? SPY : '0;
    localparam logic signed [31:0] LIM_L  = 32'(SAFETY << FP_SHIFT);
    localparam logic signed [31:0] LIM_R  = 32'((SCREEN_W - 1 - SAFETY - OBJ_W) << FP_SHIFT);
    localparam logic signed [31:0] LIM_T  = 32'(SAFETY << FP_SHIFT);
    localparam logic signed [31:0] LIM_B  = 32'((SCREEN_H - 1 - SAFETY - OBJ_H) << FP_SHIFT);
    localparam logic signed [10:0] PIX_X_INIT = 11'(INITIAL_X);
    localparam logic signed [10:0] PIX_Y_INIT = 11'(INITIAL_Y);

    // Edge classes as masks over the 16 possible hit codes
    localparam logic [15:0] MASK_LEFT   = 16'h1300;  // codes 8, 9, C
    localparam logic [15:0] MASK_RIGHT  = 16'h004C;  // codes 2, 3, 6
    localparam logic [15:0] MASK_TOP    = 16'h1050;  // codes 4, 6, C
    localparam logic [15:0] MASK_BOTTOM = 16'h020A;  // codes 1, 3, 9

    state_t             state, state_next;
    logic signed [31:0] Xpos, Ypos, Vx, Vy;
    logic signed [31:0] abs_vx, abs_vy;
    logic signed [31:0] vx_sof, vy_sof;
    logic signed [31:0] x_lim, y_lim, vx_lim, vy_lim;
    logic signed [10:0] x_pix, y_pix;
    logic               clamp_x, clamp_y;
    logic [15:0]        hit_reg;
    logic               hit_left, hit_right, hit_top, hit_bottom;
    logic               respawn_req;

    assign respawn_req = bus.respawn && (state != IDLE_ST);
    assign abs_vx      = Vx[31] ? -Vx : Vx;
    assign abs_vy      = Vy[31] ? -Vy : Vy;
    assign hit_left    = |(hit_reg & MASK_LEFT);
    assign hit_right   = |(hit_reg & MASK_RIGHT);
    assign hit_top     = |(hit_reg & MASK_TOP);
    assign hit_bottom  = |(hit_reg & MASK_BOTTOM);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE_ST;
        else       state <= state_next;
    end

    // Next-state: frame sequence MOVE -> SOF -> CHANGE -> LIMITS, respawn overrides
    always_comb begin
        state_next = state;
        if (respawn_req) begin
            state_next = IDLE_ST;
        end else begin
            case (state)
                IDLE_ST:   if (bus.startOfFrame) state_next = MOVE_ST;
                MOVE_ST:   if (bus.startOfFrame && bus.enable_sof) state_next = SOF_ST;
                SOF_ST:    state_next = CHANGE_ST;
                CHANGE_ST: state_next = LIMITS_ST;
                LIMITS_ST: state_next = MOVE_ST;
                default:   state_next = IDLE_ST;
            endcase
        end
    end

    // Frame velocity from keys (PLAYER) or collision reflection (BOUNCE)
    always_comb begin
        vx_sof = Vx;
        vy_sof = Vy;
        if (MODE == 1) begin
            if (hit_left && hit_right) vx_sof = -Vx;
            else if (hit_left)         vx_sof = abs_vx;
            else if (hit_right)        vx_sof = -abs_vx;
            if (hit_top && hit_bottom) vy_sof = -Vy;
            else if (hit_top)          vy_sof = abs_vy;
            else if (hit_bottom)       vy_sof = -abs_vy;
        end else begin
            if (bus.key_left && !bus.key_right)      vx_sof = -SPX;
            else if (bus.key_right && !bus.key_left) vx_sof = SPX;
            else                                     vx_sof = '0;
            if (bus.key_up && !bus.key_down)         vy_sof = -SPY;
            else if (bus.key_down && !bus.key_up)    vy_sof = SPY;
            else                                     vy_sof = '0;
            if ((hit_left && vx_sof < 0) || (hit_right && vx_sof > 0))  vx_sof = '0;
            if ((hit_top && vy_sof < 0) || (hit_bottom && vy_sof > 0)) vy_sof = '0;
        end
    end

    // Clamp to the visible area; the clamped axis velocity turns away from (or stops at) the wall
    always_comb begin
        x_lim   = Xpos;
        y_lim   = Ypos;
        vx_lim  = Vx;
        vy_lim  = Vy;
        clamp_x = 1'b0;
        clamp_y = 1'b0;
        if (Xpos < LIM_L) begin
            x_lim   = LIM_L;
            clamp_x = 1'b1;
            vx_lim  = (MODE == 1) ? abs_vx : '0;
        end else if (Xpos > LIM_R) begin
            x_lim   = LIM_R;
            clamp_x = 1'b1;
            vx_lim  = (MODE == 1) ? -abs_vx : '0;
        end
        if (Ypos < LIM_T) begin
            y_lim   = LIM_T;
            clamp_y = 1'b1;
            vy_lim  = (MODE == 1) ? abs_vy : '0;
        end else if (Ypos > LIM_B) begin
            y_lim   = LIM_B;
            clamp_y = 1'b1;
            vy_lim  = (MODE == 1) ? -abs_vy : '0;
        end
        x_pix = 11'(x_lim >>> FP_SHIFT);
        y_pix = 11'(y_lim >>> FP_SHIFT);
    end

    // Collision collection; a hit arriving in SOF_ST survives the per-frame clear
    always_ff @(posedge clk) begin
        if (reset || respawn_req) begin
            hit_reg <= '0;
        end else if (state == SOF_ST) begin
            hit_reg <= bus.collision ? (16'd1 << bus.HitEdgeCode) : '0;
        end else if (bus.collision) begin
            hit_reg[bus.HitEdgeCode] <= 1'b1;
        end
    end

    // Position/velocity datapath and registered outputs; frozen while a respawn is pending
    always_ff @(posedge clk) begin
        if (reset) begin
            Xpos         <= X_INIT;
            Ypos         <= Y_INIT;
            Vx           <= VX_INIT;
            Vy           <= VY_INIT;
            bus.topLeftX <= PIX_X_INIT;
            bus.topLeftY <= PIX_Y_INIT;
            bus.edge_hit <= 1'b0;
            bus.moving   <= 1'b0;
        end else begin
            bus.edge_hit <= 1'b0;
            if (!respawn_req) begin
                case (state)
                    IDLE_ST: begin
                        Xpos         <= X_INIT;
                        Ypos         <= Y_INIT;
                        Vx           <= VX_INIT;
                        Vy           <= VY_INIT;
                        bus.topLeftX <= PIX_X_INIT;
                        bus.topLeftY <= PIX_Y_INIT;
                    end
                    SOF_ST: begin
                        Vx <= vx_sof;
                        Vy <= vy_sof;
                    end
                    CHANGE_ST: begin
                        Xpos <= Xpos + Vx;
                        Ypos <= Ypos + Vy;
                    end
                    LIMITS_ST: begin
                        Xpos         <= x_lim;
                        Ypos         <= y_lim;
                        Vx           <= vx_lim;
                        Vy           <= vy_lim;
                        bus.topLeftX <= x_pix;
                        bus.topLeftY <= y_pix;
                        bus.edge_hit <= clamp_x || clamp_y;
                        bus.moving   <= (Vx != 0) || (Vy != 0);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_object_move_2d.sv
// Scoreboard bench: three movers (PLAYER default, PLAYER near right wall, BOUNCE)
// stepped frame by frame in lockstep.
module tb_object_move_2d;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       sof_p, sof_c, sof_b, en, resp_p;
    logic [3:0] p_keys, c_keys;   // {left, right, up, down}
    logic       p_col, b_col;
    logic [3:0] p_code, b_code;

    object_move_2d_if p_if();
    object_move_2d_if c_if();
    object_move_2d_if b_if();

    assign p_if.startOfFrame = sof_p;
    assign p_if.enable_sof   = en;
    assign p_if.respawn      = resp_p;
    assign {p_if.key_left, p_if.key_right, p_if.key_up, p_if.key_down} = p_keys;
    assign p_if.collision    = p_col;
    assign p_if.HitEdgeCode  = p_code;

    assign c_if.startOfFrame = sof_c;
    assign c_if.enable_sof   = en;
    assign c_if.respawn      = 1'b0;
    assign {c_if.key_left, c_if.key_right, c_if.key_up, c_if.key_down} = c_keys;
    assign c_if.collision    = 1'b0;
    assign c_if.HitEdgeCode  = 4'd0;

    assign b_if.startOfFrame = sof_b;
    assign b_if.enable_sof   = en;
    assign b_if.respawn      = 1'b0;
    assign {b_if.key_left, b_if.key_right, b_if.key_up, b_if.key_down} = 4'b0000;
    assign b_if.collision    = b_col;
    assign b_if.HitEdgeCode  = b_code;

    object_move_2d #(.MODE(0)) u_p (.clk(clk), .reset(reset), .bus(p_if));
    object_move_2d #(.MODE(0), .INITIAL_X(604), .SPEED_X(128)) u_c (.clk(clk), .reset(reset), .bus(c_if));
    object_move_2d #(.MODE(1), .SPEED_X(64), .SPEED_Y(64)) u_b (.clk(clk), .reset(reset), .bus(b_if));

    int n_cmp = 0;
    int n_err = 0;
    int last_px, next_px;
    int sb_id[$];
    int sb_exp[$];

    task automatic check_val(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int actual(input int id);
        case (id)
            0: return int'(p_if.topLeftX);
            1: return int'(p_if.topLeftY);
            2: return int'(p_if.moving);
            3: return int'(p_if.edge_hit);
            4: return int'(c_if.topLeftX);
            5: return int'(c_if.edge_hit);
            6: return int'(b_if.topLeftX);
            7: return int'(b_if.topLeftY);
            8: return int'(b_if.edge_hit);
            default: return -1;
        endcase
    endfunction

    function automatic string tag_of(input int id);
        case (id)
            0: return "p_x";
            1: return "p_y";
            2: return "p_moving";
            3: return "p_edge";
            4: return "c_x";
            5: return "c_edge";
            6: return "b_x";
            7: return "b_y";
            8: return "b_edge";
            default: return "unknown";
        endcase
    endfunction

    task automatic push_exp(input int id, input int exp);
        sb_id.push_back(id);
        sb_exp.push_back(exp);
        if (id == 0) next_px = exp;
    endtask

    task automatic expect_frame(input int px, input int py, input int pm, input int pe,
                                input int cx, input int ce, input int bx, input int by, input int be);
        push_exp(0, px); push_exp(1, py); push_exp(2, pm); push_exp(3, pe);
        push_exp(4, cx); push_exp(5, ce);
        push_exp(6, bx); push_exp(7, by); push_exp(8, be);
    endtask

    task automatic drain();
        int id, e;
        while (sb_id.size() != 0) begin
            id = sb_id.pop_front();
            e  = sb_exp.pop_front();
            check_val(tag_of(id), actual(id), e);
        end
    endtask

    // One collision cycle, then a frame pulse to all three; results expected 4 cycles after sampling
    task automatic run_frame();
        tick();
        p_col = 1'b0;
        b_col = 1'b0;
        sof_p = 1'b1; sof_c = 1'b1; sof_b = 1'b1;
        tick();
        sof_p = 1'b0; sof_c = 1'b0; sof_b = 1'b0;
        tick();
        tick();
        check_val("latency_p_x", int'(p_if.topLeftX), last_px);
        tick();
        drain();
        last_px = next_px;
        tick();
        check_val("p_edge_pulse", int'(p_if.edge_hit), 0);
        check_val("c_edge_pulse", int'(c_if.edge_hit), 0);
        check_val("b_edge_pulse", int'(b_if.edge_hit), 0);
    endtask

    initial begin
        reset = 1'b1;
        sof_p = 1'b0; sof_c = 1'b0; sof_b = 1'b0;
        en = 1'b1; resp_p = 1'b0;
        p_keys = 4'b0000; c_keys = 4'b0000;
        p_col = 1'b0; b_col = 1'b0; p_code = 4'd0; b_code = 4'd0;
        repeat (3) tick();

        check_val("rst_p_x", int'(p_if.topLeftX), 280);
        check_val("rst_p_y", int'(p_if.topLeftY), 185);
        check_val("rst_p_moving", int'(p_if.moving), 0);
        check_val("rst_p_edge", int'(p_if.edge_hit), 0);
        check_val("rst_c_x", int'(c_if.topLeftX), 604);
        check_val("rst_b_y", int'(b_if.topLeftY), 185);
        reset = 1'b0;
        tick();

        // leave IDLE_ST
        sof_p = 1'b1; sof_c = 1'b1; sof_b = 1'b1;
        tick();
        sof_p = 1'b0; sof_c = 1'b0; sof_b = 1'b0;
        tick(); tick();
        last_px = 280;

        // F1..F3: right held; c clamps at 605; b bounces off a top-right hit then a left hit
        p_keys = 4'b0100; c_keys = 4'b0100;
        expect_frame(281, 185, 1, 0, 605, 1, 281, 186, 0);
        run_frame();
        b_col = 1'b1; b_code = 4'h6;
        expect_frame(282, 185, 1, 0, 605, 1, 280, 187, 0);
        run_frame();
        b_col = 1'b1; b_code = 4'h8;
        expect_frame(283, 185, 1, 0, 605, 1, 281, 188, 0);
        run_frame();
        // F4: p released; b left hit while Vx>0 keeps moving right
        p_keys = 4'b0000;
        b_col = 1'b1; b_code = 4'h8;
        expect_frame(283, 185, 0, 0, 605, 1, 282, 189, 0);
        run_frame();
        // F5: p left into a left-edge hit stays put; c keys released
        p_keys = 4'b1000; c_keys = 4'b0000;
        p_col = 1'b1; p_code = 4'h8;
        expect_frame(283, 185, 0, 0, 605, 0, 283, 190, 0);
        run_frame();
        // F6: p right with same left-edge hit moves; c moves left
        p_keys = 4'b0100; c_keys = 4'b1000;
        p_col = 1'b1; p_code = 4'h8;
        expect_frame(284, 185, 1, 0, 603, 0, 284, 191, 0);
        run_frame();

        // frozen frames
        en = 1'b0; c_keys = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            expect_frame(284, 185, 1, 0, 603, 0, 284, 191, 0);
            run_frame();
        end
        en = 1'b1;
        expect_frame(285, 185, 1, 0, 603, 0, 285, 192, 0);
        run_frame();

        // reset while in CHANGE_ST
        sof_p = 1'b1; sof_c = 1'b1; sof_b = 1'b1;
        tick();
        sof_p = 1'b0; sof_c = 1'b0; sof_b = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check_val("midrst_p_x", int'(p_if.topLeftX), 280);
        check_val("midrst_p_y", int'(p_if.topLeftY), 185);
        check_val("midrst_p_moving", int'(p_if.moving), 0);
        check_val("midrst_c_x", int'(c_if.topLeftX), 604);
        check_val("midrst_b_x", int'(b_if.topLeftX), 280);
        reset = 1'b0;
        tick();
        check_val("idle_hold_p_x", int'(p_if.topLeftX), 280);

        sof_p = 1'b1; sof_c = 1'b1; sof_b = 1'b1;
        tick();
        sof_p = 1'b0; sof_c = 1'b0; sof_b = 1'b0;
        tick(); tick();
        last_px = 280;

        // walk p to 300
        p_keys = 4'b0100;
        for (int i = 1; i <= 20; i++) begin
            expect_frame(280 + i, 185, 1, 0, 604, 0, 280 + i, 185 + i, 0);
            run_frame();
        end

        // respawn in MOVE_ST
        resp_p = 1'b1;
        tick();
        resp_p = 1'b0;
        check_val("resp_hold_x", int'(p_if.topLeftX), 300);
        tick();
        check_val("resp_x", int'(p_if.topLeftX), 280);
        check_val("resp_y", int'(p_if.topLeftY), 185);

        sof_p = 1'b1;
        tick();
        sof_p = 1'b0;
        tick(); tick();
        last_px = 280;
        expect_frame(281, 185, 1, 0, 604, 0, 301, 206, 0);
        run_frame();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
